// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit bitwise logic unit.
// One operation in flight; the registered result is held until the consumer takes it.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             ptr_r;
    logic             id_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             resp_valid_r;
    logic             resp_id_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             busy_r;

    logic             gnt_valid_s;
    logic             gnt_id_s;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~(a | b);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Grant decision: only in IDLE; on contention the pointer picks the winner.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = ptr_r;
            end else if (req0_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_id_s    = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
    end

    assign req0_ready = gnt_valid_s & ~gnt_id_s;
    assign req1_ready = gnt_valid_s &  gnt_id_s;

    // Control FSM with operand latch and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= 1'b0;
            id_r         <= 1'b0;
            op_r         <= 2'b00;
            a_r          <= '0;
            b_r          <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        id_r    <= gnt_id_s;
                        a_r     <= gnt_id_s ? req1_a  : req0_a;
                        b_r     <= gnt_id_s ? req1_b  : req0_b;
                        op_r    <= gnt_id_s ? req1_op : req0_op;
                        ptr_r   <= ~gnt_id_s;
                        busy_r  <= 1'b1;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_r  <= logic_op(op_r, a_r, b_r);
                    resp_id_r    <= id_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    // resp_data/resp_id intentionally keep their last value after transfer.
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter: inputs driven and outputs
// sampled around the falling edge, expected values hand-computed.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;
    localparam logic [31:0] OPA = 32'hF0F0F0F0;
    localparam logic [31:0] OPB = 32'h0FF00FF0;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [1:0]       req1_op;
    logic             resp_valid, resp_ready, resp_id, busy;
    logic [WIDTH-1:0] resp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    // Advance one full cycle, landing on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_id, busy, req0_ready, req1_ready} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {resp_valid, resp_id, busy, req0_ready, req1_ready});
        end
        checks++;
        if (resp_data !== 32'h00000000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000", resp_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nor_req0();
        req0_valid = 1'b1; req0_a = OPA; req0_b = OPB; req0_op = 2'b10; resp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            failures++;
            $display("FAIL nor_grant got=%b exp=100", {req0_ready, req1_ready, busy});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if ({busy, resp_valid, req0_ready} !== 3'b100) begin
            failures++;
            $display("FAIL nor_exec got=%b exp=100", {busy, resp_valid, req0_ready});
        end
        step();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'h000F000F}) begin
            failures++;
            $display("FAIL nor_resp got=%b/%b/%h exp=1/0/000f000f", resp_valid, resp_id, resp_data);
        end
        step();
        checks++;
        if ({resp_valid, busy, resp_data} !== {1'b0, 1'b0, 32'h000F000F}) begin
            failures++;
            $display("FAIL nor_idle got=%b/%b/%h exp=0/0/000f000f", resp_valid, busy, resp_data);
        end
    endtask

    task automatic test_req1_ops();
        logic [1:0]  ops [3];
        logic [31:0] exps[3];
        ops  = '{2'b00, 2'b01, 2'b11};
        exps = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00};
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1; req1_a = OPA; req1_b = OPB; req1_op = ops[i];
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                failures++;
                $display("FAIL req1_grant%0d got=%b exp=10", i, {req1_ready, req0_ready});
            end
            step();
            req1_valid = 1'b0;
            step();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, exps[i]}) begin
                failures++;
                $display("FAIL req1_resp%0d got=%b/%b/%h exp=1/1/%h", i, resp_valid, resp_id, resp_data, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_alternate();
        logic [31:0] exp;
        req0_valid = 1'b1; req0_a = OPA; req0_b = OPB; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = OPA; req1_b = OPB; req1_op = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 32'h000F000F : 32'h00F000F0;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL alt_grant%0d got=%b exp=%b", k, {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                failures++;
                $display("FAIL alt_exec_ready%0d got=%b exp=00", k, {req0_ready, req1_ready});
            end
            step();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, (k % 2 == 1), exp}) begin
                failures++;
                $display("FAIL alt_resp%0d got=%b/%b/%h exp=1/%0d/%h", k, resp_valid, resp_id, resp_data, k % 2, exp);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_a = OPA; req0_b = OPB; req0_op = 2'b11;
        req1_valid = 1'b1; req1_a = OPA; req1_b = OPB; req1_op = 2'b01;
        resp_ready = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        step();
        for (int j = 0; j < 5; j++) begin
            checks++;
            if ({resp_valid, resp_id, resp_data, req1_ready, busy} !== {1'b1, 1'b0, 32'hFF00FF00, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%b/%h rdy1=%b busy=%b exp=1/0/ff00ff00 rdy1=0 busy=1",
                         j, resp_valid, resp_id, resp_data, req1_ready, busy);
            end
            if (j < 4) step();
        end
        resp_ready = 1'b1;
        step();
        #1;
        checks++;
        if ({resp_valid, req1_ready, req0_ready} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release got=%b exp=010", {resp_valid, req1_ready, req0_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'hFFF0FFF0}) begin
            failures++;
            $display("FAIL bp_req1_resp got=%b/%b/%h exp=1/1/fff0fff0", resp_valid, resp_id, resp_data);
        end
        step();
    endtask

    task automatic test_operand_change();
        req0_valid = 1'b1; req0_a = 32'h00000000; req0_b = 32'h00000000; req0_op = 2'b10;
        step();
        req0_valid = 1'b0;
        req0_a     = 32'hFFFFFFFF;
        step();
        checks++;
        if ({resp_valid, resp_data} !== {1'b1, 32'hFFFFFFFF}) begin
            failures++;
            $display("FAIL latched_operand got=%b/%h exp=1/ffffffff", resp_valid, resp_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        // Abort in EXEC.
        req0_valid = 1'b1; req0_a = OPA; req0_b = OPB; req0_op = 2'b10; resp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_exec got=%b exp=00", {resp_valid, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_exec_noresp got=%b exp=00", {resp_valid, busy});
        end
        // Abort in RESP.
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_resp got=%b exp=00", {resp_valid, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = OPA; req1_b = OPB; req1_op = 2'b00;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rst_ptr_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'h000F000F}) begin
            failures++;
            $display("FAIL rst_after_resp got=%b/%b/%h exp=1/0/000f000f", resp_valid, resp_id, resp_data);
        end
        step();
    endtask

    initial begin
        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
        test_reset();
        test_nor_req0();
        test_req1_ops();
        test_alternate();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
